// File: rtl/fft_pkg.sv
// Types and helpers shared by the forward and inverse 4-point FFT blocks.
package fft_pkg;

    typedef struct packed {
        logic signed [7:0] im;
        logic signed [7:0] re;
    } cplx_t;

    typedef enum logic [2:0] {
        IDLE,
        BF0,
        BF1,
        BF2,
        BF3,
        DONE
    } ifft_state_e;

    // x * +j = (-im, re); -(-128) has no 8-bit encoding, so it clamps to +127.
    function automatic cplx_t cmul_j(input cplx_t x);
        cplx_t y;
        y.re = (x.im == 8'sh80) ? 8'sh7f : -x.im;
        y.im = x.re;
        return y;
    endfunction

endpackage

// File: rtl/ifft_bfly_r2.sv
// Combinational scaled radix-2 DIF butterfly: p = (a+b)>>>1, q = ((a-b)>>>1) * w, w in {1, +j}.
module ifft_bfly_r2
    import fft_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        tw_j,
    output logic [15:0] p,
    output logic [15:0] q
);

    cplx_t ca;
    cplx_t cb;
    cplx_t cp;
    cplx_t cd;
    logic signed [8:0] sum_re;
    logic signed [8:0] sum_im;
    logic signed [8:0] dif_re;
    logic signed [8:0] dif_im;

    assign ca = a;
    assign cb = b;

    // 9-bit sums never overflow; dropping bit 0 is a floor divide by two.
    assign sum_re = {ca.re[7], ca.re} + {cb.re[7], cb.re};
    assign sum_im = {ca.im[7], ca.im} + {cb.im[7], cb.im};
    assign dif_re = {ca.re[7], ca.re} - {cb.re[7], cb.re};
    assign dif_im = {ca.im[7], ca.im} - {cb.im[7], cb.im};

    always_comb begin
        cp    = '0;
        cd    = '0;
        cp.re = sum_re[8:1];
        cp.im = sum_im[8:1];
        cd.re = dif_re[8:1];
        cd.im = dif_im[8:1];
    end

    assign p = cp;
    assign q = tw_j ? cmul_j(cd) : cd;

endmodule

// File: rtl/ifft_4p_seq.sv
// Sequential 4-point inverse FFT: one shared butterfly stepped by an FSM over an in-place
// 4-entry work file, valid/ready on both sides, natural-order output.
module ifft_4p_seq
    import fft_pkg::*;
#(
    parameter int N            = 4,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N-1:0][SAMPLE_WIDTH-1:0]    data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N-1:0][SAMPLE_WIDTH-1:0]    data_out
);

    if (N != 4) begin : g_bad_n
        $error("ifft_4p_seq: N must be 4");
    end
    if (SAMPLE_WIDTH != 16) begin : g_bad_sw
        $error("ifft_4p_seq: SAMPLE_WIDTH must be 16");
    end

    ifft_state_e state;
    cplx_t       work [4];
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        tw_j;
    logic [15:0] bf_p;
    logic [15:0] bf_q;

    always_comb begin
        op_a = work[0];
        op_b = work[2];
        tw_j = 1'b0;
        case (state)
            BF1: begin
                op_a = work[1];
                op_b = work[3];
                tw_j = 1'b1;
            end
            BF2: begin
                op_a = work[0];
                op_b = work[1];
            end
            BF3: begin
                op_a = work[2];
                op_b = work[3];
            end
            default: ;
        endcase
    end

    ifft_bfly_r2 u_bfly (
        .a    (op_a),
        .b    (op_b),
        .tw_j (tw_j),
        .p    (bf_p),
        .q    (bf_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            for (int k = 0; k < 4; k++) begin
                work[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < 4; k++) begin
                            work[k] <= data_in[k];
                        end
                        in_ready <= 1'b0;
                        state    <= BF0;
                    end
                end
                BF0: begin
                    work[0] <= bf_p;
                    work[2] <= bf_q;
                    state   <= BF1;
                end
                BF1: begin
                    work[1] <= bf_p;
                    work[3] <= bf_q;
                    state   <= BF2;
                end
                BF2: begin
                    work[0] <= bf_p;
                    work[1] <= bf_q;
                    state   <= BF3;
                end
                BF3: begin
                    work[2]     <= bf_p;
                    work[3]     <= bf_q;
                    // Bit-reverse unscramble: y1 lives in w2, y2 in w1.
                    data_out[0] <= work[0];
                    data_out[1] <= bf_p;
                    data_out[2] <= work[1];
                    data_out[3] <= bf_q;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_4p_seq.sv
// Self-checking bench for ifft_4p_seq: directed frames, backpressure, mid-frame reset, random frames.
module tb_ifft_4p_seq;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][15:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [3:0][15:0] data_out;

    logic dir_ready;
    logic rnd_ready;
    logic rnd_mode;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int nsent  = 0;
    int nout   = 0;

    logic [63:0] sb[$];

    assign out_ready = rnd_mode ? rnd_ready : dir_ready;

    ifft_4p_seq #(.N(4), .SAMPLE_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: floating-point IFFT arithmetic with floor after each halving and +j saturation.
    function automatic int fl2(input int v);
        return int'($floor(real'(v) / 2.0));
    endfunction

    function automatic logic [63:0] model(input logic [63:0] x);
        int xr[4];
        int xi[4];
        int ar[4];
        int ai[4];
        int yr[4];
        int yi[4];
        logic [63:0] y;
        for (int k = 0; k < 4; k++) begin
            xr[k] = int'($signed(x[16*k +: 8]));
            xi[k] = int'($signed(x[16*k+8 +: 8]));
        end
        ar[0] = fl2(xr[0] + xr[2]);  ai[0] = fl2(xi[0] + xi[2]);
        ar[2] = fl2(xr[0] - xr[2]);  ai[2] = fl2(xi[0] - xi[2]);
        ar[1] = fl2(xr[1] + xr[3]);  ai[1] = fl2(xi[1] + xi[3]);
        ar[3] = -fl2(xi[1] - xi[3]); ai[3] = fl2(xr[1] - xr[3]);
        if (ar[3] > 127) ar[3] = 127;
        yr[0] = fl2(ar[0] + ar[1]);  yi[0] = fl2(ai[0] + ai[1]);
        yr[2] = fl2(ar[0] - ar[1]);  yi[2] = fl2(ai[0] - ai[1]);
        yr[1] = fl2(ar[2] + ar[3]);  yi[1] = fl2(ai[2] + ai[3]);
        yr[3] = fl2(ar[2] - ar[3]);  yi[3] = fl2(ai[2] - ai[3]);
        y = '0;
        for (int k = 0; k < 4; k++) begin
            y[16*k +: 8]   = 8'(yr[k]);
            y[16*k+8 +: 8] = 8'(yi[k]);
        end
        return y;
    endfunction

    // Output side: an output handshake is about to happen at the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("sb_depth", 64'(sb.size()), 64'd1);
            if (sb.size() != 0) begin
                chk("frame", data_out, sb.pop_front());
                nout++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the input handshake edge.
    task automatic send(input logic [63:0] x, input logic [63:0] exp, output int c0);
        int n = 0;
        in_valid = 1'b1;
        data_in  = x;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", 64'(in_ready), 64'd1);
        sb.push_back(exp);
        nsent++;
        @(posedge clk);
        #1;
        c0       = cyc;
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(sb.size() == 0 && in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] x;
        logic [63:0] cap;
        int c0;
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        dir_ready = 1'b1;
        rnd_mode  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Impulse, with latency measurement.
        send(64'h0000_0000_0000_0004, 64'h0001_0001_0001_0001, c0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(cyc - c0), 64'd4);
        drain();

        // DC and single tone.
        send(64'h0004_0004_0004_0004, 64'h0000_0000_0000_0004, c0);
        drain();
        send(64'h0000_0000_0004_0000, 64'hFF00_00FF_0100_0001, c0);
        drain();

        // Saturation and floor.
        x = 64'h0000_0000_8000_0000;
        send(x, model(x), c0);
        drain();
        x = 64'h7F00_0000_8000_0000;
        send(x, model(x), c0);
        drain();
        send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, c0);
        drain();

        // Backpressure: hold for three cycles, ignore new input, release.
        dir_ready = 1'b0;
        x = {$urandom, $urandom};
        send(x, model(x), c0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        cap = data_out;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            data_in  = {$urandom, $urandom};
            @(negedge clk);
            chk("bp_hold_data", data_out, cap);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        dir_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_ready", 64'(in_ready), 64'd1);
        chk("bp_idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset while in BF2; the partial frame is dropped.
        x = {$urandom, $urandom};
        send(x, model(x), c0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        nsent--;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(64'h0000_0000_0000_0004, 64'h0001_0001_0001_0001, c0);
        drain();

        // Random frames under random backpressure.
        rnd_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            send(x, model(x), c0);
        end
        drain();
        rnd_mode = 1'b0;

        chk("frame_count", 64'(nout), 64'(nsent));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
